rf_wb_writer: RTL



---
 rtl/rf_wb_writer.sv | 108 ++++++++++
 1 files changed

// File: rtl/rf_wb_writer.sv
// Write-back queue driving the 32x32 register file write port, with read-port forwarding.
// Define RF_WB_FWD_EN to build the forwarding search; without it the fwd outputs are tied to 0.
module rf_wb_writer #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_data,
  output logic        WrEn,
  output logic [4:0]  Rw,
  output logic [31:0] busW,
  input  logic [4:0]  Ra,
  input  logic [4:0]  Rb,
  output logic        fwdA_hit,
  output logic        fwdB_hit,
  output logic [31:0] fwdA_data,
  output logic [31:0] fwdB_data,
  output logic [31:0] wr_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic          push;
  logic          enq;
  logic          pop;

  // Handshake: a beat transfers on any rising edge where in_valid && in_ready;
  // in_ready depends only on the registered count, never on in_valid.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Beats that write nothing (no wen, or r0) complete the handshake but are dropped.
  assign enq      = push && in_wen && (in_rd != 5'd0);
  assign pop      = (count != '0);

  assign WrEn = pop;
  assign Rw   = pop ? rd_q[head]   : 5'd0;
  assign busW = pop ? data_q[head] : 32'd0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wr_count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) begin
        head     <= head + 1'b1;
        wr_count <= wr_count + 32'd1;
      end
      if (enq && !pop)      count <= count + 1'b1;
      else if (!enq && pop) count <= count - 1'b1;
    end
  end

  // Payload storage needs no reset: count alone decides which slots are live.
  always_ff @(posedge Clk) begin
    if (enq) begin
      rd_q[tail]   <= in_rd;
      data_q[tail] <= in_data;
    end
  end

`ifdef RF_WB_FWD_EN
  logic [AW-1:0] idx;

  // Walk from head (oldest) to tail (youngest) so the last match wins.
  always_comb begin
    fwdA_hit  = 1'b0;
    fwdA_data = 32'd0;
    fwdB_hit  = 1'b0;
    fwdB_data = 32'd0;
    idx       = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count) begin
        if ((Ra != 5'd0) && (rd_q[idx] == Ra)) begin
          fwdA_hit  = 1'b1;
          fwdA_data = data_q[idx];
        end
        if ((Rb != 5'd0) && (rd_q[idx] == Rb)) begin
          fwdB_hit  = 1'b1;
          fwdB_data = data_q[idx];
        end
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{Ra, Rb};
  assign fwdA_hit   = 1'b0;
  assign fwdB_hit   = 1'b0;
  assign fwdA_data  = 32'd0;
  assign fwdB_data  = 32'd0;
`endif

endmodule
